slave_port: RTL and testbench

- Bus-side front end of a slave, directly downstream of the master port on the serial system bus.
- Accepts a read or write request from the granted master through the valid/ready handshake.
- Deserialises the bit-serial address and write data, then drives a synchronous memory (block RAM) interface.
- For reads, serialises the read data back to the master.
- One instance per slave. The bus interconnect routes the selected master's signals to it.

---
 rtl/slave_port_pkg.sv | 23 ++
 rtl/serial_shift_reg.sv | 39 +++
 rtl/slave_port.sv | 164 ++++++++++++++++
 tb/tb_slave_port.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/slave_port_pkg.sv
// Shared definitions for the serial system bus: transaction states, op encoding and
// default serial field lengths used by slave port, master port and arbiter.
package slave_port_pkg;

  localparam int unsigned AddrLen = 12;
  localparam int unsigned DataLen = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRxAddr,
    StRxData,
    StWrite,
    StReadWait,
    StTxWait,
    StTxData
  } state_e;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } op_e;

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load shift register. Serial data enters at the MSB and leaves at the LSB,
// so an LSB-first stream lands in natural bit order after Width shifts.
module serial_shift_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             shift_in_i,
  input  logic             serial_i,
  input  logic             shift_out_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_in_i) begin
      data_d = {serial_i, data_q[Width-1:1]};
    end else if (shift_out_i) begin
      data_d = {1'b0, data_q[Width-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/slave_port.sv
// Slave-side bus front end: deserialises address/write data, drives a synchronous
// memory port and serialises read data back to the master.
module slave_port
  import slave_port_pkg::*;
#(
  parameter int unsigned ADDR_LEN     = AddrLen,
  parameter int unsigned DATA_LEN     = DataLen,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                master_valid,
  input  logic                write_en,
  input  logic                read_en,
  input  logic                rx_address,
  input  logic                rx_data,
  input  logic                master_ready,
  output logic                slave_ready,
  output logic                slave_valid,
  output logic                tx_data,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic                mem_we,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  localparam int unsigned MaxLen = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
  localparam int unsigned CntW   = $clog2(MaxLen + 1);

  state_e          state_d, state_q;
  op_e             op_d, op_q;
  logic [CntW-1:0] cnt_d, cnt_q;

  logic                addr_shift;
  logic                wdata_shift;
  logic                tx_load;
  logic                tx_shift;
  logic [DATA_LEN-1:0] tx_word;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    addr_shift  = 1'b0;
    wdata_shift = 1'b0;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Exactly one of write/read must be requested; anything else is ignored.
        if (master_valid && (write_en ^ read_en)) begin
          op_d    = write_en ? OpWrite : OpRead;
          cnt_d   = '0;
          state_d = StRxAddr;
        end
      end
      StRxAddr: begin
        addr_shift = 1'b1;
        if (cnt_q == CntW'(ADDR_LEN - 1)) begin
          cnt_d   = '0;
          state_d = (op_q == OpWrite) ? StRxData : StReadWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRxData: begin
        wdata_shift = 1'b1;
        if (cnt_q == CntW'(DATA_LEN - 1)) begin
          cnt_d   = '0;
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      StReadWait: begin
        if (cnt_q == CntW'(READ_LATENCY - 1)) begin
          tx_load = 1'b1;
          cnt_d   = '0;
          state_d = StTxWait;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StTxWait: begin
        if (master_ready) begin
          state_d = StTxData;
        end
      end
      StTxData: begin
        tx_shift = 1'b1;
        if (cnt_q == CntW'(DATA_LEN - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpRead;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  serial_shift_reg #(
    .Width (ADDR_LEN)
  ) u_addr_sr (
    .clk_i       (clk),
    .rst_i       (reset),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_in_i  (addr_shift),
    .serial_i    (rx_address),
    .shift_out_i (1'b0),
    .data_o      (mem_addr)
  );

  serial_shift_reg #(
    .Width (DATA_LEN)
  ) u_wdata_sr (
    .clk_i       (clk),
    .rst_i       (reset),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_in_i  (wdata_shift),
    .serial_i    (rx_data),
    .shift_out_i (1'b0),
    .data_o      (mem_wdata)
  );

  serial_shift_reg #(
    .Width (DATA_LEN)
  ) u_tx_sr (
    .clk_i       (clk),
    .rst_i       (reset),
    .load_i      (tx_load),
    .load_data_i (mem_rdata),
    .shift_in_i  (1'b0),
    .serial_i    (1'b0),
    .shift_out_i (tx_shift),
    .data_o      (tx_word)
  );

  // Moore outputs decoded from the state register only.
  assign slave_ready = (state_q == StIdle);
  assign slave_valid = (state_q == StTxWait);
  assign mem_we      = (state_q == StWrite);
  assign tx_data     = (state_q == StTxData) & tx_word[0];

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port with a combinational-read memory model.
module tb_slave_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        master_valid, write_en, read_en;
  logic        rx_address, rx_data, master_ready;
  logic        slave_ready, slave_valid, tx_data;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:4095];
  int          we_count = 0;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  slave_port #(
    .ADDR_LEN     (12),
    .DATA_LEN     (8),
    .READ_LATENCY (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .master_valid (master_valid),
    .write_en     (write_en),
    .read_en      (read_en),
    .rx_address   (rx_address),
    .rx_data      (rx_data),
    .master_ready (master_ready),
    .slave_ready  (slave_ready),
    .slave_valid  (slave_valid),
    .tx_data      (tx_data),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
      we_count      <= we_count + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake at T0, address T1..T12, data T13..T20, strobe expected at T21.
  task automatic do_write(input logic [11:0] a, input logic [7:0] d);
    int we0;
    we0          = we_count;
    master_valid = 1'b1;
    write_en     = 1'b1;
    step();
    master_valid = 1'b0;
    write_en     = 1'b0;
    chk("wr_busy", {31'd0, slave_ready}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      rx_address = a[i];
      step();
    end
    rx_address = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx_data = d[i];
      step();
    end
    rx_data = 1'b0;
    chk("wr_we_t21", {31'd0, mem_we}, 32'd1);
    chk("wr_addr", {20'd0, mem_addr}, {20'd0, a});
    chk("wr_wdata", {24'd0, mem_wdata}, {24'd0, d});
    chk("wr_no_early_we", we_count, we0);
    step();
    chk("wr_we_t22", {31'd0, mem_we}, 32'd0);
    chk("wr_ready_t22", {31'd0, slave_ready}, 32'd1);
    chk("wr_we_once", we_count, we0 + 1);
  endtask

  task automatic do_read(input logic [11:0] a, input logic [7:0] exp, input int delay);
    master_valid = 1'b1;
    read_en      = 1'b1;
    master_ready = (delay == 0);
    step();
    master_valid = 1'b0;
    read_en      = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rx_address = a[i];
      step();
    end
    rx_address = 1'b0;
    chk("rd_t13_valid", {31'd0, slave_valid}, 32'd0);
    step();
    chk("rd_t14_valid", {31'd0, slave_valid}, 32'd1);
    chk("rd_t14_tx", {31'd0, tx_data}, 32'd0);
    for (int w = 0; w < delay; w++) begin
      step();
      chk("rd_wait_valid", {31'd0, slave_valid}, 32'd1);
      chk("rd_wait_tx", {31'd0, tx_data}, 32'd0);
    end
    master_ready = 1'b1;
    step();
    master_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rd_bit%0d", i), {31'd0, tx_data}, {31'd0, exp[i]});
      chk("rd_bit_valid", {31'd0, slave_valid}, 32'd0);
      step();
    end
    chk("rd_end_tx", {31'd0, tx_data}, 32'd0);
    chk("rd_end_ready", {31'd0, slave_ready}, 32'd1);
  endtask

  initial begin
    int we0;
    reset        = 1'b1;
    master_valid = 1'b0;
    write_en     = 1'b0;
    read_en      = 1'b0;
    rx_address   = 1'b0;
    rx_data      = 1'b0;
    master_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ready", {31'd0, slave_ready}, 32'd1);
    chk("rst_valid", {31'd0, slave_valid}, 32'd0);
    chk("rst_tx", {31'd0, tx_data}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {20'd0, mem_addr}, 32'h0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'h0);
    step();

    do_write(12'h3C7, 8'hA5);
    do_read(12'h3C7, 8'hA5, 0);

    // Both-high and both-low requests must be ignored.
    we0          = we_count;
    master_valid = 1'b1;
    write_en     = 1'b1;
    read_en      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ill_both_ready", {31'd0, slave_ready}, 32'd1);
    end
    write_en = 1'b0;
    read_en  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ill_none_ready", {31'd0, slave_ready}, 32'd1);
    end
    master_valid = 1'b0;
    chk("ill_no_we", we_count, we0);

    do_write(12'h001, 8'h5A);
    do_read(12'h001, 8'h5A, 5);

    // Reset pulsed at T15 of a write (inside the data phase).
    we0          = we_count;
    master_valid = 1'b1;
    write_en     = 1'b1;
    step();
    master_valid = 1'b0;
    write_en     = 1'b0;
    for (int i = 1; i < 15; i++) begin
      rx_address = 1'b1;
      rx_data    = 1'b1;
      step();
    end
    reset = 1'b1;
    step();
    reset      = 1'b0;
    rx_address = 1'b0;
    rx_data    = 1'b0;
    chk("abort_ready", {31'd0, slave_ready}, 32'd1);
    chk("abort_addr", {20'd0, mem_addr}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
    end
    chk("abort_no_we", we_count, we0);
    chk("abort_idle", {31'd0, slave_ready}, 32'd1);

    do_write(12'hFFF, 8'hFF);
    do_read(12'hFFF, 8'hFF, 2);
    do_read(12'h3C7, 8'hA5, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
